phy_tx_stripe: RTL and testbench
================================

# phy_tx_stripe

Parametrised transmit-side byte un-striper for the PCIe PHY path. It accepts one word per lane per cycle from `LANES` parallel lanes, buffers each lane in its own FIFO, and emits complete frames serially, one word per cycle in lane order 0..`LANES`-1. A single clock replaces the multi-clock arrangement of the earlier 4-lane transmitter. The block adds per-lane backpressure and overflow reporting.

## Interface
- `LANES`, 4: number of input lanes, ≥2.
- `DATA_W`, 8: word width per lane.
- `DEPTH`, 4: entries per lane FIFO, power of two, ≥2.
- `IDLE_SYM`, 8'hBC: idle symbol; used only with `PHY_TX_IDLE_EN`.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `data_in`  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- `valid_in`  in  LANES  per-lane write strobe.
- `ready_out`  out  LANES  lane k FIFO not full.
- `data_out`  out  DATA_W  serialized word, registered.
- `valid_out`  out  1  `data_out` carries a frame word, registered.
- `lane_out`  out  $clog2(LANES)  source lane of the current `data_out`.
- `overflow`  out  LANES  sticky: a write was dropped on lane k.

## Operation
- Write: lane k stores `data_in` lane k when `valid_in[k]` is high and `ready_out[k]` is high. If `valid_in[k]` is high while `ready_out[k]` is low, the word is dropped and `overflow[k]` sets. `overflow[k]` stays set until reset.
- `ready_out[k]` = count_k < `DEPTH`, from registered count only. When a lane is full, a write is refused even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: lane pointer `ptr`=0, `valid_out`=0. Go to SEND when every lane count ≥1.
  - SEND: pop lane `ptr` into the output register, set `valid_out`=1 and `lane_out`=`ptr`, then advance `ptr`.
  - At `ptr`=`LANES`-1, `ptr` wraps to 0. Stay in SEND iff lanes 0..`LANES`-2 have count ≥1 and lane `LANES`-1 has count ≥2. Otherwise go to IDLE.
- Frames are gapless. Once SEND starts, a full frame of `LANES` words is emitted on consecutive cycles. A frame is never partial.
- Push and pop on the same lane in the same cycle: the count is unchanged, and both the data and the order are preserved. The FIFO has no empty-bypass.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `lane_out`=0, `overflow`=0, all counts 0, `ready_out`=all ones, FSM=IDLE, `ptr`=0.
- Reset is asserted asynchronously and released synchronously to `clk`. Assertion mid-frame discards all buffered data. No partial frame is emitted after reset.
- Latency: if the last lane of a frame becomes valid in cycle c, lane 0's word appears on `data_out` in cycle c+2. The remaining lanes follow in cycles c+3..c+1+`LANES`.
- Throughput: 1 word per cycle sustained, provided that each lane is written at ≥1/`LANES` of the cycles.

## Configuration
- `PHY_TX_IDLE_EN` defined: whenever `valid_out`=0, `data_out`=`IDLE_SYM` (including the reset value).
- `PHY_TX_IDLE_EN` not defined: `data_out` holds its last value when `valid_out`=0, and resets to 0.

## Structure
- Shared package `phy_tx_pkg`:
  - FSM state typedef (IDLE, SEND).
  - Default `IDLE_SYM` constant.
  - Lane-index width function.
- One natural sub-module: `phy_tx_lane_fifo` (DATA_W, DEPTH), instantiated `LANES` times. It provides push, pop, data, count and full.
- Top level: FSM, pointer, output register.

## Test plan
- Reset: drive `reset_L`=0 -> all outputs at their reset values, `ready_out`=4'b1111. With `PHY_TX_IDLE_EN` defined, `data_out`=8'hBC.
- Single frame: write 8'h11, 22, 33, 44 on lanes 0..3 in one cycle c -> `data_out` = 11, 22, 33, 44 in cycles c+2..c+5, with `lane_out` = 0..3 and `valid_out` = 1 for exactly 4 cycles.
- Staggered lanes: write lanes 0..2 in cycle c and lane 3 in cycle c+5 -> `valid_out` stays 0 until cycle c+7, then a gapless frame follows.
- Back-to-back frames: write all lanes every cycle for 3 cycles -> 12 consecutive valid words, in lane order, with no gap.
- Overflow: write lane 2 for 5 cycles while other lanes are idle (`DEPTH`=4) -> `ready_out[2]`=0 after the 4th write, the 5th write is dropped, and `overflow`=4'b0100 stays sticky.
- Mid-frame reset: assert `reset_L` during the 2nd word of a frame -> outputs return to reset values immediately. After release, no residual words are emitted.

Source files
------------

// File: rtl/phy_tx_pkg.sv
// Shared types and helpers for the phy_tx_stripe transmit un-striper.
package phy_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

  // Width of a lane index; never narrower than one bit.
  function automatic int unsigned lane_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/phy_tx_lane_fifo.sv
// Per-lane FIFO: push refused when full, no empty bypass, head word always visible on dout.
module phy_tx_lane_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W-1:0]           dout,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    push_ok = push && !full;
    pop_ok  = pop && (cnt_q != '0);
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phy_tx_stripe.sv
// Transmit un-striper: LANES per-lane FIFOs drained as gapless frames, one word per cycle.
// Build option PHY_TX_IDLE_EN: drive IDLE_SYM on data_out whenever valid_out is low.
module phy_tx_stripe
  import phy_tx_pkg::*;
#(
  parameter int unsigned      LANES    = 4,
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [DATA_W-1:0] IDLE_SYM = DATA_W'(IDLE_SYM_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic [LANES*DATA_W-1:0]     data_in,
  input  logic [LANES-1:0]            valid_in,
  output logic [LANES-1:0]            ready_out,
  output logic [DATA_W-1:0]           data_out,
  output logic                        valid_out,
  output logic [lane_w(LANES)-1:0]    lane_out,
  output logic [LANES-1:0]            overflow
);

  localparam int unsigned LW = lane_w(LANES);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef PHY_TX_IDLE_EN
  localparam logic IDLE_EN = 1'b1;
`else
  localparam logic IDLE_EN = 1'b0;
`endif
  localparam logic [DATA_W-1:0] RST_DATA = IDLE_EN ? IDLE_SYM : '0;

  state_e            state_q, state_d;
  logic [LW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [LANES-1:0]  ovf_q, ovf_d;

  logic [LANES-1:0]  push;
  logic [LANES-1:0]  pop;
  logic [LANES-1:0]  full;
  logic [DATA_W-1:0] head [LANES];
  logic [CW-1:0]     cnt  [LANES];
  logic              all_ge1;
  logic              front_ge1;
  logic              last_ge2;
  logic              pop_en;
  logic [LW-1:0]     pop_lane;

  assign ready_out = ~full;
  assign push      = valid_in & ~full;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;
  assign overflow  = ovf_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    phy_tx_lane_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset_L(reset_L),
      .push   (push[g]),
      .pop    (pop[g]),
      .din    (data_in[g*DATA_W +: DATA_W]),
      .dout   (head[g]),
      .count  (cnt[g]),
      .full   (full[g])
    );
  end

  // Frame readiness; the last lane needs a second word to chain a frame because its head is popped now.
  always_comb begin
    front_ge1 = 1'b1;
    for (int i = 0; i < LANES - 1; i++) begin
      if (cnt[i] == '0) front_ge1 = 1'b0;
    end
    all_ge1  = front_ge1 && (cnt[LANES-1] != '0);
    last_ge2 = (cnt[LANES-1] >= CW'(2));
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      data_q  <= RST_DATA;
      valid_q <= 1'b0;
      lane_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (all_ge1) state_d = ST_SEND;
      ST_SEND: if ((ptr_q == LW'(LANES - 1)) && !(front_ge1 && last_ge2)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane 0 is popped on the cycle the frame is recognised so it lands in the output register at once.
  always_comb begin
    pop      = '0;
    pop_en   = 1'b0;
    pop_lane = '0;
    ptr_d    = '0;
    data_d   = IDLE_EN ? IDLE_SYM : data_q;
    valid_d  = 1'b0;
    lane_d   = lane_q;
    ovf_d    = ovf_q | (valid_in & full);
    case (state_q)
      ST_IDLE: pop_en = all_ge1;
      ST_SEND: begin
        pop_en   = 1'b1;
        pop_lane = ptr_q;
      end
      default: pop_en = 1'b0;
    endcase
    if (pop_en) begin
      pop[pop_lane] = 1'b1;
      data_d        = head[pop_lane];
      valid_d       = 1'b1;
      lane_d        = pop_lane;
      ptr_d         = (pop_lane == LW'(LANES - 1)) ? '0 : pop_lane + LW'(1);
    end
  end

endmodule

// File: tb/tb_phy_tx_stripe.sv
// Self-checking bench for phy_tx_stripe (LANES=4, DATA_W=8, DEPTH=4) with a frame-word scoreboard.
module tb_phy_tx_stripe;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] l;
  } exp_t;

`ifdef PHY_TX_IDLE_EN
  localparam logic       IDLE_EN = 1'b1;
`else
  localparam logic       IDLE_EN = 1'b0;
`endif
  localparam logic [7:0] RST_DATA = IDLE_EN ? 8'hBC : 8'h00;

  logic        clk;
  logic        reset_L;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic [3:0]  ready_out;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  lane_out;
  logic [3:0]  overflow;

  int   n_checks;
  int   n_pass;
  exp_t sb [$];

  phy_tx_stripe #(
    .LANES (4),
    .DATA_W(8),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .valid_out(valid_out),
    .lane_out (lane_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every valid output word must match the next expected word.
  always @(negedge clk) begin
    exp_t e;
    if (reset_L && valid_out) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got data=%h lane=%0d, no word expected", data_out, lane_out);
      end else begin
        e = sb.pop_front();
        if (data_out !== e.d || lane_out !== e.l)
          $display("FAIL sb_word: got data=%h lane=%0d, want data=%h lane=%0d",
                   data_out, lane_out, e.d, e.l);
        else
          n_pass++;
      end
    end
  end

  // One cycle: drive inputs just after the rising edge, return at the falling edge for sampling.
  task automatic step(input logic [31:0] d, input logic [3:0] v);
    @(posedge clk);
    #1;
    data_in  = d;
    valid_in = v;
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [3:0] lanes);
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) sb.push_back('{d: d[i*8 +: 8], l: 2'(i)});
    end
  endtask

  task automatic check_valid(input string name, input int k, input logic exp);
    n_checks++;
    if (valid_out !== exp)
      $display("FAIL %s: cycle c+%0d valid_out=%b want %b", name, k, valid_out, exp);
    else
      n_pass++;
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (data_out !== RST_DATA || valid_out !== 1'b0 || lane_out !== 2'd0 ||
        overflow !== 4'b0000 || ready_out !== 4'b1111)
      $display("FAIL %s: data=%h valid=%b lane=%0d ovf=%b ready=%b want data=%h valid=0 lane=0 ovf=0000 ready=1111",
               name, data_out, valid_out, lane_out, overflow, ready_out, RST_DATA);
    else
      n_pass++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_L  = 1'b0;
    data_in  = '0;
    valid_in = '0;
    #1;
    check_reset_outputs("reset_values");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    check_reset_outputs("reset_release");
  endtask

  task automatic test_single_frame;
    step(32'h44332211, 4'hF);
    push_frame(32'h44332211, 4'hF);
    for (int k = 1; k <= 6; k++) begin
      step('0, 4'h0);
      check_valid("single_valid", k, (k >= 2 && k <= 5));
    end
    n_checks++;
    if (data_out !== (IDLE_EN ? 8'hBC : 8'h44))
      $display("FAIL single_hold: data_out=%h want %h", data_out, IDLE_EN ? 8'hBC : 8'h44);
    else
      n_pass++;
  endtask

  task automatic test_staggered;
    step(32'h00A3A2A1, 4'h7);
    push_frame(32'h00A3A2A1, 4'h7);
    for (int k = 1; k <= 11; k++) begin
      if (k == 5) begin
        step(32'hA4000000, 4'h8);
        push_frame(32'hA4000000, 4'h8);
      end else begin
        step('0, 4'h0);
      end
      check_valid("stagger_valid", k, (k >= 7 && k <= 10));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    for (int k = 0; k <= 14; k++) begin
      if (k < 3) begin
        d = {8'(8'h40 + 8'(k)), 8'(8'h30 + 8'(k)), 8'(8'h20 + 8'(k)), 8'(8'h10 + 8'(k))};
        step(d, 4'hF);
        push_frame(d, 4'hF);
      end else begin
        step('0, 4'h0);
      end
      if (k >= 1) check_valid("b2b_valid", k, (k >= 2 && k <= 13));
    end
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL b2b_drain: %0d words still expected, want 0", sb.size());
    else
      n_pass++;
  endtask

  task automatic test_overflow;
    for (int k = 0; k <= 4; k++) begin
      step({8'h00, 8'(8'h50 + 8'(k)), 16'h0000}, 4'h4);
      n_checks++;
      if (ready_out[2] !== (k < 4) || overflow !== 4'b0000)
        $display("FAIL ovf_fill: write %0d ready[2]=%b ovf=%b want ready[2]=%b ovf=0000",
                 k, ready_out[2], overflow, (k < 4));
      else
        n_pass++;
    end
    for (int k = 5; k <= 10; k++) begin
      step('0, 4'h0);
      n_checks++;
      if (ready_out !== 4'b1011 || overflow !== 4'b0100 || valid_out !== 1'b0)
        $display("FAIL ovf_sticky: cycle %0d ready=%b ovf=%b valid=%b want ready=1011 ovf=0100 valid=0",
                 k, ready_out, overflow, valid_out);
      else
        n_pass++;
    end
  endtask

  task automatic test_mid_frame_reset;
    step(32'hD4D3D2D1, 4'hF);
    push_frame(32'hD4D3D2D1, 4'hF);
    for (int k = 1; k <= 3; k++) step('0, 4'h0);
    n_checks++;
    if (valid_out !== 1'b1 || lane_out !== 2'd1)
      $display("FAIL midrst_pre: valid=%b lane=%0d want valid=1 lane=1", valid_out, lane_out);
    else
      n_pass++;
    #1;
    reset_L = 1'b0;
    #1;
    check_reset_outputs("midrst_async");
    sb.delete();
    @(negedge clk);
    reset_L = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step('0, 4'h0);
      check_valid("midrst_quiet", k, 1'b0);
    end
    check_reset_outputs("midrst_after");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_L  = 1'b0;
    data_in  = '0;
    valid_in = '0;
    test_reset();
    test_single_frame();
    test_staggered();
    test_back_to_back();
    test_overflow();
    test_reset();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
